du: RTL and testbench

- Iterative 32-bit divide unit for the RV32M divide/remainder instructions (DIV, DIVU, REM, REMU).
- Counterpart to the multiply unit `mu`. Sits beside `mu` in the datapath and uses the same start/done handshake, so the control FSM drives both identically.
- Radix-2 restoring algorithm: one quotient bit per clock, with sign and special-case handling.

---
 rtl/du_if.sv | 30 +++
 rtl/du.sv | 145 ++++++++++++++
 tb/tb_du.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/du_if.sv
// du_if: request/response bundle for the iterative divide unit.
//   start  - request strobe, taken only while the divider is idle
//   a, b   - dividend and divisor
//   divctl - 00 DIV, 01 DIVU, 10 REM, 11 REMU (funct3[1:0])
//   divres - quotient or remainder, held until the next completion
//   done   - one-cycle completion pulse, divres valid in the same cycle
//   busy   - high while an iterative division is in flight
// The master modport is the requester (control FSM / bench); the slave
// modport is the divide unit itself.
interface du_if #(
   parameter int XLEN = 32
);
   logic            start;
   logic [XLEN-1:0] a;
   logic [XLEN-1:0] b;
   logic [1:0]      divctl;
   logic [XLEN-1:0] divres;
   logic            done;
   logic            busy;

   modport master (
      output start, a, b, divctl,
      input  divres, done, busy
   );

   modport slave (
      input  start, a, b, divctl,
      output divres, done, busy
   );
endinterface

// File: rtl/du.sv
// du: iterative radix-2 restoring divider for DIV, DIVU, REM and REMU.
// Shares the start/done handshake of the multiply unit so the control FSM
// can drive both identically.
//   clk   - clock, all state changes on the rising edge
//   rst_n - asynchronous active-low reset, aborts any division in flight
//   bus   - du_if slave modport (start, a, b, divctl in; divres, done, busy out)
// Divide-by-zero and signed overflow finish on the accepting edge; every
// other request takes 32 shift/subtract edges plus one sign-fix edge.
module du #(
   parameter int XLEN = 32
) (
   input logic clk,
   input logic rst_n,
   du_if.slave bus
);

   localparam int CW = $clog2(XLEN);

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      FIX
   } state_t;

   state_t            state;
   logic [XLEN-1:0]   rem;
   logic [XLEN-1:0]   dvd;
   logic [XLEN-1:0]   divisor;
   logic [XLEN-1:0]   divres;
   logic [CW-1:0]     count;
   logic              q_neg;
   logic              r_neg;
   logic              op_rem;
   logic              done;
   logic              busy;

   logic              is_signed;
   logic              div_zero;
   logic              overflow;
   logic [XLEN-1:0]   abs_a;
   logic [XLEN-1:0]   abs_b;
   logic [XLEN:0]     rem_sh;
   logic [XLEN:0]     trial;
   logic [XLEN-1:0]   q_fixed;
   logic [XLEN-1:0]   r_fixed;

   assign bus.divres = divres;
   assign bus.done   = done;
   assign bus.busy   = busy;

   // Request decode: the odd divctl encodings are the unsigned ops, and
   // the two special cases are recognised directly from the live operands
   // so they can complete on the same edge that accepts them.
   always_comb begin
      is_signed = ~bus.divctl[0];
      div_zero  = (bus.b == '0);
      overflow  = is_signed
                  && (bus.a == {1'b1, {(XLEN-1){1'b0}}})
                  && (bus.b == {XLEN{1'b1}});
      abs_a     = (is_signed && bus.a[XLEN-1]) ? -bus.a : bus.a;
      abs_b     = (is_signed && bus.b[XLEN-1]) ? -bus.b : bus.b;
   end

   // One restoring step. The partial remainder is always below the divisor,
   // so the shifted value fits in XLEN+1 bits and the top bit of the
   // subtraction is a reliable "went negative" flag.
   always_comb begin
      rem_sh  = {rem, dvd[XLEN-1]};
      trial   = rem_sh - {1'b0, divisor};
      q_fixed = q_neg ? -dvd : dvd;
      r_fixed = r_neg ? -rem : rem;
   end

   // Control FSM with registered outputs. dvd starts as |dividend| and is
   // shifted out from the top while quotient bits enter at the bottom, so
   // after 32 steps it holds the unsigned quotient.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         rem     <= '0;
         dvd     <= '0;
         divisor <= '0;
         divres  <= '0;
         count   <= '0;
         q_neg   <= 1'b0;
         r_neg   <= 1'b0;
         op_rem  <= 1'b0;
         done    <= 1'b0;
         busy    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (bus.start) begin
                  op_rem <= bus.divctl[1];
                  if (div_zero) begin
                     divres <= bus.divctl[1] ? bus.a : {XLEN{1'b1}};
                     done   <= 1'b1;
                  end else if (overflow) begin
                     divres <= bus.divctl[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
                     done   <= 1'b1;
                  end else begin
                     dvd     <= abs_a;
                     divisor <= abs_b;
                     q_neg   <= is_signed && (bus.a[XLEN-1] ^ bus.b[XLEN-1]);
                     r_neg   <= is_signed && bus.a[XLEN-1];
                     rem     <= '0;
                     count   <= '0;
                     busy    <= 1'b1;
                     state   <= BUSY;
                  end
               end
            end

            BUSY: begin
               done <= 1'b0;
               if (trial[XLEN]) begin
                  rem <= rem_sh[XLEN-1:0];
               end else begin
                  rem <= trial[XLEN-1:0];
               end
               dvd   <= {dvd[XLEN-2:0], ~trial[XLEN]};
               count <= count + 1'b1;
               if (count == {CW{1'b1}}) begin
                  state <= FIX;
               end
            end

            FIX: begin
               divres <= op_rem ? r_fixed : q_fixed;
               done   <= 1'b1;
               busy   <= 1'b0;
               state  <= IDLE;
            end

            default: begin
               state <= IDLE;
               done  <= 1'b0;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_du.sv
// tb_du: directed self-checking bench for the divide unit.
// Each request is applied, the edges until done are counted, and the
// result, latency and busy flag are compared against hand-computed values.
module tb_du;

   logic clk;
   logic rst_n;
   int   numCompared;
   int   numMismatched;
   int   pulses;

   du_if #(.XLEN(32)) bus ();

   du #(.XLEN(32)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // Free-running 100 MHz clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Single comparison point: counts every check and reports a mismatch
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      numCompared++;
      if (observed !== expected) begin
         numMismatched++;
         $display("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   // Issue one request from the current time, count edges until done and
   // check result, latency and busy. pokeAt >= 0 disturbs the operands (and
   // optionally re-pulses start) that many edges after acceptance.
   task automatic applyStimulus(input string tag, input logic [31:0] opA,
                                input logic [31:0] opB, input logic [1:0] ctl,
                                input logic [31:0] expRes, input int expLat,
                                input int pokeAt, input bit pokeStart);
      int lat;
      bus.a      = opA;
      bus.b      = opB;
      bus.divctl = ctl;
      bus.start  = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      lat = 0;
      checkOutput({tag, "/busy"}, {31'b0, bus.busy}, (expLat != 0) ? 32'd1 : 32'd0);
      while (!bus.done && lat < 40) begin
         if (lat == pokeAt) begin
            bus.a      = 32'hDEADBEEF;
            bus.b      = 32'd3;
            bus.divctl = 2'b00;
            bus.start  = pokeStart;
         end else if (lat == pokeAt + 1) begin
            bus.start = 1'b0;
         end
         @(posedge clk);
         #1;
         lat++;
      end
      bus.start = 1'b0;
      checkOutput({tag, "/lat"}, 32'(lat), 32'(expLat));
      checkOutput({tag, "/res"}, bus.divres, expRes);
   endtask

   // Safety net so the run always ends
   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      numCompared   = 0;
      numMismatched = 0;
      rst_n      = 1'b0;
      bus.start  = 1'b0;
      bus.a      = '0;
      bus.b      = '0;
      bus.divctl = 2'b00;
      #1;
      checkOutput("reset/divres", bus.divres, 32'd0);
      checkOutput("reset/done", {31'b0, bus.done}, 32'd0);
      checkOutput("reset/busy", {31'b0, bus.busy}, 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // Signed
      applyStimulus("div_m7_2",  32'hFFFFFFF9, 32'd2, 2'b00, 32'hFFFFFFFD, 33, -1, 1'b0);
      applyStimulus("rem_m7_2",  32'hFFFFFFF9, 32'd2, 2'b10, 32'hFFFFFFFF, 33, -1, 1'b0);
      applyStimulus("rem_7_m2",  32'd7, 32'hFFFFFFFE, 2'b10, 32'd1, 33, -1, 1'b0);
      applyStimulus("div_m100_m7", 32'hFFFFFF9C, 32'hFFFFFFF9, 2'b00, 32'd14, 33, -1, 1'b0);
      applyStimulus("rem_m100_7", 32'hFFFFFF9C, 32'd7, 2'b10, 32'hFFFFFFFE, 33, -1, 1'b0);

      // Unsigned
      @(negedge clk);
      applyStimulus("divu_big_2", 32'hFFFFFFF9, 32'd2, 2'b01, 32'h7FFFFFFC, 33, -1, 1'b0);
      applyStimulus("remu_big_2", 32'hFFFFFFF9, 32'd2, 2'b11, 32'd1, 33, -1, 1'b0);
      applyStimulus("divu_16_48", 32'd16, 32'd48, 2'b01, 32'd0, 33, -1, 1'b0);
      applyStimulus("remu_16_48", 32'd16, 32'd48, 2'b11, 32'd16, 33, -1, 1'b0);

      // Divide by zero, all four ops finish on the accepting edge
      @(negedge clk);
      applyStimulus("div_5_0",  32'd5, 32'd0, 2'b00, 32'hFFFFFFFF, 0, -1, 1'b0);
      applyStimulus("divu_5_0", 32'd5, 32'd0, 2'b01, 32'hFFFFFFFF, 0, -1, 1'b0);
      applyStimulus("rem_5_0",  32'd5, 32'd0, 2'b10, 32'd5, 0, -1, 1'b0);
      applyStimulus("remu_5_0", 32'd5, 32'd0, 2'b11, 32'd5, 0, -1, 1'b0);
      @(posedge clk);
      #1;
      checkOutput("div0/donePulse", {31'b0, bus.done}, 32'd0);
      checkOutput("div0/busyLow", {31'b0, bus.busy}, 32'd0);

      // Signed overflow, plus the unsigned version of the same operands
      @(negedge clk);
      applyStimulus("div_ovf",  32'h80000000, 32'hFFFFFFFF, 2'b00, 32'h80000000, 0, -1, 1'b0);
      applyStimulus("rem_ovf",  32'h80000000, 32'hFFFFFFFF, 2'b10, 32'd0, 0, -1, 1'b0);
      applyStimulus("divu_ovf", 32'h80000000, 32'hFFFFFFFF, 2'b01, 32'd0, 33, -1, 1'b0);
      @(posedge clk);
      #1;
      checkOutput("divu_ovf/donePulse", {31'b0, bus.done}, 32'd0);

      // Handshake: second start mid-operation is ignored
      @(negedge clk);
      applyStimulus("ignore_start", 32'd100, 32'd7, 2'b01, 32'd14, 33, 10, 1'b1);
      // Operand change mid-operation has no effect
      @(negedge clk);
      applyStimulus("opnd_change", 32'd100, 32'd7, 2'b11, 32'd2, 33, 5, 1'b0);
      // Start in the done cycle is accepted
      checkOutput("b2b/doneHigh", {31'b0, bus.done}, 32'd1);
      applyStimulus("b2b_second", 32'd1000, 32'd9, 2'b01, 32'd111, 33, -1, 1'b0);

      // Reset mid-operation aborts without a done pulse
      @(negedge clk);
      bus.a      = 32'd100;
      bus.b      = 32'd7;
      bus.divctl = 2'b01;
      bus.start  = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      repeat (14) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      checkOutput("rstmid/divres", bus.divres, 32'd0);
      checkOutput("rstmid/busy", {31'b0, bus.busy}, 32'd0);
      checkOutput("rstmid/done", {31'b0, bus.done}, 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      pulses = 0;
      repeat (40) begin
         @(posedge clk);
         #1;
         if (bus.done) pulses++;
      end
      checkOutput("rstmid/noDone", 32'(pulses), 32'd0);
      applyStimulus("after_rst", 32'd100, 32'd7, 2'b01, 32'd14, 33, -1, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", numCompared, numMismatched);
      $finish;
   end

endmodule
